// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Prefill FIFO between the DMA and the JESD204 TPL DAC core. Streaming starts once a
// programmable level is reached. Underflows are flagged, latched and counted.
module ad_ip_jesd204_tpl_dac_fifo #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dma_valid,
    output logic                     dma_ready,
    input  logic [DATA_WIDTH-1:0]    dma_data,
    input  logic                     dac_valid,
    output logic [DATA_WIDTH-1:0]    dac_ddata,
    input  logic [ADDRESS_WIDTH:0]   cfg_threshold,
    input  logic                     cfg_rearm,
    input  logic                     flush,
    output logic                     dac_dunf,
    output logic                     dunf_sticky,
    output logic [15:0]              dunf_count,
    output logic [ADDRESS_WIDTH:0]   level
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam int unsigned LW    = ADDRESS_WIDTH + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [1:0]               state;
    logic [LW-1:0]            thr_eff;
    logic                     wr_en;
    logic                     rd_en;
    logic                     unf;

    // Threshold of zero still needs one word; anything beyond the depth is unreachable.
    always_comb begin
        thr_eff = cfg_threshold;
        if (cfg_threshold > LVL_FULL) begin
            thr_eff = LVL_FULL;
        end else if (cfg_threshold == '0) begin
            thr_eff = LW'(1);
        end
    end

    assign dma_ready = !reset && !flush && (level < LVL_FULL);
    assign wr_en     = dma_valid && dma_ready;
    assign rd_en     = (state == ST_STREAM) && dac_valid && (level != '0);
    assign unf       = (state == ST_STREAM) && dac_valid && (level == '0);

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= dma_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            dac_ddata   <= '0;
            dac_dunf    <= 1'b0;
            dunf_sticky <= 1'b0;
            dunf_count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
            end

            if (rd_en) begin
                dac_ddata <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDRESS_WIDTH'(1);
            end else if (unf) begin
                dac_ddata <= '0;
            end

            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            dac_dunf <= unf;
            if (unf) begin
                dunf_sticky <= 1'b1;
                if (dunf_count != 16'hFFFF) begin
                    dunf_count <= dunf_count + 16'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (wr_en) state <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (level >= thr_eff) state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (unf && cfg_rearm) state <= ST_PREFILL;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Self-checking bench for the TPL DAC prefill FIFO: threshold table plus directed
// prefill, full, underflow, re-arm, flush/reset and streaming scenarios.
module tb_ad_ip_jesd204_tpl_dac_fifo;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PREFILL = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        dma_valid;
    logic        dma_ready;
    logic [63:0] dma_data;
    logic        dac_valid;
    logic [63:0] dac_ddata;
    logic [4:0]  cfg_threshold;
    logic        cfg_rearm;
    logic        flush;
    logic        dac_dunf;
    logic        dunf_sticky;
    logic [15:0] dunf_count;
    logic [4:0]  level;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [4:0] thr;
        int         n;
        logic [1:0] st;
    } vec_t;
    vec_t vecs[8];

    ad_ip_jesd204_tpl_dac_fifo #(.DATA_WIDTH(64), .ADDRESS_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_data(dma_data),
        .dac_valid(dac_valid), .dac_ddata(dac_ddata),
        .cfg_threshold(cfg_threshold), .cfg_rearm(cfg_rearm), .flush(flush),
        .dac_dunf(dac_dunf), .dunf_sticky(dunf_sticky), .dunf_count(dunf_count),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected <no word queued>", nm, dac_ddata);
        end else begin
            chk(nm, dac_ddata, exp_q.pop_front());
        end
    endtask

    task automatic write_n(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            dma_valid = 1'b1;
            dma_data  = base + 64'(i);
            cyc();
            exp_q.push_back(base + 64'(i));
        end
        dma_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{thr: 5'd0,  n: 1,  st: S_STREAM};
        vecs[1] = '{thr: 5'd1,  n: 1,  st: S_STREAM};
        vecs[2] = '{thr: 5'd5,  n: 4,  st: S_PREFILL};
        vecs[3] = '{thr: 5'd5,  n: 5,  st: S_STREAM};
        vecs[4] = '{thr: 5'd16, n: 16, st: S_STREAM};
        vecs[5] = '{thr: 5'd20, n: 16, st: S_STREAM};
        vecs[6] = '{thr: 5'd31, n: 15, st: S_PREFILL};
        vecs[7] = '{thr: 5'd0,  n: 0,  st: S_IDLE};

        reset = 1'b1; dma_valid = 1'b0; dma_data = '0; dac_valid = 1'b0;
        cfg_threshold = 5'd8; cfg_rearm = 1'b0; flush = 1'b0;
        cyc(); cyc();
        chk("rst_ready", 64'(dma_ready), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ddata", dac_ddata, 64'd0);
        chk("rst_dunf", 64'(dac_dunf), 64'd0);
        chk("rst_sticky", 64'(dunf_sticky), 64'd0);
        chk("rst_count", 64'(dunf_count), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(S_IDLE));
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(dma_ready), 64'd1);

        // Threshold table: state after n writes plus one settle cycle.
        for (int v = 0; v < 8; v++) begin
            do_flush();
            cfg_threshold = vecs[v].thr;
            write_n(vecs[v].n, 64'h50 * 64'(v));
            cyc();
            chk($sformatf("thr_state[%0d]", v), 64'(dut.state), 64'(vecs[v].st));
            chk($sformatf("thr_level[%0d]", v), 64'(level), 64'(vecs[v].n));
        end

        // Prefill with dac_valid held high.
        do_flush();
        cfg_threshold = 5'd8;
        dac_valid = 1'b1;
        write_n(8, 64'd0);
        chk("pf_ddata_after_wr", dac_ddata, 64'd0);
        chk("pf_state_after_wr", 64'(dut.state), 64'(S_PREFILL));
        cyc();
        chk("pf_state_stream", 64'(dut.state), 64'(S_STREAM));
        chk("pf_ddata_no_pop", dac_ddata, 64'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            pop_chk($sformatf("pf_pop[%0d]", k));
            chk($sformatf("pf_dunf[%0d]", k), 64'(dac_dunf), 64'd0);
        end
        dac_valid = 1'b0;
        chk("pf_level_end", 64'(level), 64'd0);
        chk("pf_sticky_end", 64'(dunf_sticky), 64'd0);

        // Full.
        do_flush();
        write_n(16, 64'h100);
        chk("full_level", 64'(level), 64'd16);
        chk("full_ready", 64'(dma_ready), 64'd0);
        dma_valid = 1'b1; dma_data = 64'hdead;
        cyc();
        chk("full_stall_level", 64'(level), 64'd16);
        dma_valid = 1'b0;
        dac_valid = 1'b1;
        cyc();
        dac_valid = 1'b0;
        pop_chk("full_pop");
        chk("full_ready_again", 64'(dma_ready), 64'd1);
        chk("full_level_15", 64'(level), 64'd15);

        // Underflow without re-arm.
        cfg_rearm = 1'b0;
        dac_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc();
            pop_chk($sformatf("drain_pop[%0d]", k));
            chk($sformatf("drain_dunf[%0d]", k), 64'(dac_dunf), 64'd0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("unf_pulse[%0d]", k), 64'(dac_dunf), 64'd1);
            chk($sformatf("unf_ddata[%0d]", k), dac_ddata, 64'd0);
        end
        dac_valid = 1'b0;
        cyc();
        chk("unf_dunf_low", 64'(dac_dunf), 64'd0);
        chk("unf_count", 64'(dunf_count), 64'd3);
        chk("unf_sticky", 64'(dunf_sticky), 64'd1);
        chk("unf_state", 64'(dut.state), 64'(S_STREAM));

        // Flush at level 9 in STREAM, coinciding with a write.
        write_n(10, 64'h200);
        dac_valid = 1'b1;
        cyc();
        dac_valid = 1'b0;
        pop_chk("fl_pop");
        chk("fl_level_9", 64'(level), 64'd9);
        flush = 1'b1; dma_valid = 1'b1; dma_data = 64'hbeef;
        cyc();
        chk("fl_ready_low", 64'(dma_ready), 64'd0);
        flush = 1'b0; dma_valid = 1'b0;
        exp_q.delete();
        chk("fl_level", 64'(level), 64'd0);
        chk("fl_state", 64'(dut.state), 64'(S_IDLE));
        chk("fl_ddata", dac_ddata, 64'd0);
        chk("fl_count", 64'(dunf_count), 64'd0);
        chk("fl_sticky", 64'(dunf_sticky), 64'd0);

        // Re-arm, with a write landing in the underflow cycle.
        cfg_threshold = 5'd2;
        write_n(2, 64'h300);
        cyc();
        cfg_rearm = 1'b1;
        dac_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            pop_chk($sformatf("ra_pop[%0d]", k));
        end
        dma_valid = 1'b1; dma_data = 64'h3aa;
        cyc();
        exp_q.push_back(64'h3aa);
        dma_valid = 1'b0;
        chk("ra_dunf", 64'(dac_dunf), 64'd1);
        chk("ra_ddata", dac_ddata, 64'd0);
        chk("ra_state", 64'(dut.state), 64'(S_PREFILL));
        chk("ra_level", 64'(level), 64'd1);
        chk("ra_count", 64'(dunf_count), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("ra_quiet_dunf[%0d]", k), 64'(dac_dunf), 64'd0);
            chk($sformatf("ra_quiet_count[%0d]", k), 64'(dunf_count), 64'd1);
            chk($sformatf("ra_quiet_ddata[%0d]", k), dac_ddata, 64'd0);
        end
        dac_valid = 1'b0;
        cfg_rearm = 1'b0;

        // Reset mid-run at level 9.
        write_n(8, 64'h400);
        chk("rs_level_9", 64'(level), 64'd9);
        reset = 1'b1; dma_valid = 1'b1; dma_data = 64'hcafe;
        cyc();
        chk("rs_ready", 64'(dma_ready), 64'd0);
        chk("rs_level", 64'(level), 64'd0);
        chk("rs_state", 64'(dut.state), 64'(S_IDLE));
        chk("rs_count", 64'(dunf_count), 64'd0);
        chk("rs_sticky", 64'(dunf_sticky), 64'd0);
        chk("rs_ddata", dac_ddata, 64'd0);
        cyc();
        chk("rs_ready_held", 64'(dma_ready), 64'd0);
        reset = 1'b0; dma_valid = 1'b0;
        exp_q.delete();
        cfg_threshold = 5'd1;
        dac_valid = 1'b1;
        write_n(1, 64'h500);
        chk("rs_new_prefill_ddata", dac_ddata, 64'd0);
        chk("rs_new_prefill_state", 64'(dut.state), 64'(S_PREFILL));
        cyc();
        chk("rs_stream_ddata", dac_ddata, 64'd0);
        chk("rs_stream_state", 64'(dut.state), 64'(S_STREAM));
        cyc();
        dac_valid = 1'b0;
        pop_chk("rs_first_pop");

        // Simultaneous write and read at level 5 across pointer wrap.
        do_flush();
        cfg_threshold = 5'd5;
        write_n(5, 64'h1000);
        cyc();
        chk("sim_state", 64'(dut.state), 64'(S_STREAM));
        dac_valid = 1'b1;
        dma_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dma_data = 64'h2000 + 64'(i);
            cyc();
            exp_q.push_back(64'h2000 + 64'(i));
            pop_chk($sformatf("sim_pop[%0d]", i));
            chk($sformatf("sim_level[%0d]", i), 64'(level), 64'd5);
        end
        dma_valid = 1'b0;
        dac_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
